// File: rtl/tp_fifo_pkg.sv
// Shared constants and helpers for the tp FIFO family: default geometry,
// read-mode encodings and a constant-foldable clog2.
package tp_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH          = 32;
    localparam int DEFAULT_DEPTH_LOG2          = 9;
    localparam int DEFAULT_ALMOST_EMPTY_OFFSET = 128;
    localparam int DEFAULT_ALMOST_FULL_OFFSET  = 128;

    localparam int FWFT_STANDARD    = 0;
    localparam int FWFT_FALLTHROUGH = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tp_sdp_ram.sv
// Simple-dual-port storage: one write port, one read port with a registered
// output that clears on reset so the buffer's DO starts at zero.
module tp_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Array contents are deliberately not reset; only the output register is.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tp_trackparam_buffer.sv
// Track-parameter FIFO: pointer/count control and registered status flags
// around a block-RAM store; FWFT mode reuses the RAM read register as head stage.
module tp_trackparam_buffer
    import tp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2          = DEFAULT_DEPTH_LOG2,
    parameter int FWFT                = FWFT_STANDARD,
    parameter int ALMOST_EMPTY_OFFSET = DEFAULT_ALMOST_EMPTY_OFFSET,
    parameter int ALMOST_FULL_OFFSET  = DEFAULT_ALMOST_FULL_OFFSET
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  WREN,
    input  logic                  RDEN,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOSTEMPTY,
    output logic                  ALMOSTFULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  WRERR,
    output logic                  RDERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(ALMOST_EMPTY_OFFSET);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_data_width
        $error("tp_trackparam_buffer: DATA_WIDTH %0d outside 1..72", DATA_WIDTH);
    end
    if (DEPTH_LOG2 < 4 || DEPTH_LOG2 > 12) begin : g_bad_depth
        $error("tp_trackparam_buffer: DEPTH_LOG2 %0d outside 4..12", DEPTH_LOG2);
    end
    if (FWFT != FWFT_STANDARD && FWFT != FWFT_FALLTHROUGH) begin : g_bad_fwft
        $error("tp_trackparam_buffer: FWFT %0d must be 0 or 1", FWFT);
    end
    if (ALMOST_EMPTY_OFFSET < 0 || ALMOST_EMPTY_OFFSET >= DEPTH) begin : g_bad_ae
        $error("tp_trackparam_buffer: ALMOST_EMPTY_OFFSET %0d must be in 0..DEPTH-1", ALMOST_EMPTY_OFFSET);
    end
    if (ALMOST_FULL_OFFSET < 0 || ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_af
        $error("tp_trackparam_buffer: ALMOST_FULL_OFFSET %0d must be in 0..DEPTH-1", ALMOST_FULL_OFFSET);
    end

    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [CNT_W-1:0]      ram_cnt;
    logic                  valid_q;
    logic                  valid_d;
    logic                  empty_q;
    logic                  empty_d;
    logic                  full_q;
    logic                  aempty_q;
    logic                  afull_q;
    logic                  wrerr_q;
    logic                  rderr_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd;

    always_comb begin
        wr_acc  = WREN && !full_q && !RESET;
        rd_acc  = RDEN && !empty_q && !RESET;
        // Words still inside the RAM; in FWFT mode the head sits in the read register.
        ram_cnt = count_q - CNT_W'(valid_q);
        if (FWFT == FWFT_FALLTHROUGH) begin
            ram_rd  = (ram_cnt != '0) && (!valid_q || rd_acc) && !RESET;
            valid_d = ram_rd || (valid_q && !rd_acc);
            empty_d = !valid_d;
        end else begin
            ram_rd  = rd_acc;
            valid_d = rd_acc;
            empty_d = 1'b0;
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        if (FWFT != FWFT_FALLTHROUGH) begin
            empty_d = (count_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (ram_rd) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            count_q  <= count_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= (count_d == DEPTH_C);
            aempty_q <= (count_d <= AE_LEVEL);
            afull_q  <= (count_d >= AF_LEVEL);
            wrerr_q  <= WREN && full_q;
            rderr_q  <= RDEN && empty_q;
        end
    end

    tp_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (DI),
        .rd_en_i   (ram_rd),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (DO)
    );

    assign VALID       = valid_q;
    assign EMPTY       = empty_q;
    assign FULL        = full_q;
    assign ALMOSTEMPTY = aempty_q;
    assign ALMOSTFULL  = afull_q;
    assign COUNT       = count_q;
    assign WRERR       = wrerr_q;
    assign RDERR       = rderr_q;

endmodule

// File: tb/tb_tp_trackparam_buffer.sv
// Bench for tp_trackparam_buffer: standard and FWFT instances share stimulus and
// are compared every cycle against queue-based reference models.
module tb_tp_trackparam_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WREN;
    logic        RDEN;
    logic [31:0] DI;

    logic [31:0] do_s, do_f;
    logic        valid_s, valid_f, empty_s, empty_f, full_s, full_f;
    logic        ae_s, ae_f, af_s, af_f, wrerr_s, wrerr_f, rderr_s, rderr_f;
    logic [9:0]  count_s, count_f;

    always #5 CLK = ~CLK;

    tp_trackparam_buffer #(.FWFT(0)) u_std (
        .CLK(CLK), .RESET(RESET), .DI(DI), .WREN(WREN), .RDEN(RDEN),
        .DO(do_s), .VALID(valid_s), .EMPTY(empty_s), .FULL(full_s),
        .ALMOSTEMPTY(ae_s), .ALMOSTFULL(af_s), .COUNT(count_s),
        .WRERR(wrerr_s), .RDERR(rderr_s)
    );

    tp_trackparam_buffer #(.FWFT(1)) u_fwft (
        .CLK(CLK), .RESET(RESET), .DI(DI), .WREN(WREN), .RDEN(RDEN),
        .DO(do_f), .VALID(valid_f), .EMPTY(empty_f), .FULL(full_f),
        .ALMOSTEMPTY(ae_f), .ALMOSTFULL(af_f), .COUNT(count_f),
        .WRERR(wrerr_f), .RDERR(rderr_f)
    );

    typedef struct {
        logic [31:0] w;
        int          wc;
    } ent_t;

    // Reference state: words in FIFO order; FWFT entries remember their write cycle.
    logic [31:0] q0[$];
    ent_t        q1[$];
    int          cyc;
    int          last_pop1;
    logic        exp_valid0;
    logic [31:0] exp_do0;
    logic [31:0] last_do1;
    logic        exp_wrerr0, exp_rderr0, exp_wrerr1, exp_rderr1;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (failure #%0d, cycle %0d)",
                   tag, obs, exp, n_fail, cyc);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last_pop1  = -100;
        exp_valid0 = 1'b0;
        exp_do0    = '0;
        last_do1   = '0;
        exp_wrerr0 = 1'b0;
        exp_rderr0 = 1'b0;
        exp_wrerr1 = 1'b0;
        exp_rderr1 = 1'b0;
    endtask

    // A FWFT word is on DO two cycles after its write, and no earlier than the
    // cycle after the previous head was popped.
    function automatic logic head_vis1();
        int t;
        if (q1.size() == 0) return 1'b0;
        t = q1[0].wc + 2;
        if (last_pop1 + 1 > t) t = last_pop1 + 1;
        return (t <= cyc);
    endfunction

    task automatic check_all();
        logic        v1;
        logic [31:0] d1;
        chk("std_count",  64'(count_s), 64'(q0.size()));
        chk("std_full",   64'(full_s),  64'(q0.size() == 512));
        chk("std_afull",  64'(af_s),    64'(q0.size() >= 384));
        chk("std_aempty", 64'(ae_s),    64'(q0.size() <= 128));
        chk("std_empty",  64'(empty_s), 64'(q0.size() == 0));
        chk("std_valid",  64'(valid_s), 64'(exp_valid0));
        chk("std_do",     64'(do_s),    64'(exp_do0));
        chk("std_wrerr",  64'(wrerr_s), 64'(exp_wrerr0));
        chk("std_rderr",  64'(rderr_s), 64'(exp_rderr0));
        v1 = head_vis1();
        d1 = last_do1;
        if (v1) d1 = q1[0].w;
        chk("fwft_count",  64'(count_f), 64'(q1.size()));
        chk("fwft_full",   64'(full_f),  64'(q1.size() == 512));
        chk("fwft_afull",  64'(af_f),    64'(q1.size() >= 384));
        chk("fwft_aempty", 64'(ae_f),    64'(q1.size() <= 128));
        chk("fwft_empty",  64'(empty_f), 64'(!v1));
        chk("fwft_valid",  64'(valid_f), 64'(v1));
        chk("fwft_do",     64'(do_f),    64'(d1));
        chk("fwft_wrerr",  64'(wrerr_f), 64'(exp_wrerr1));
        chk("fwft_rderr",  64'(rderr_f), 64'(exp_rderr1));
    endtask

    task automatic step(input logic rst, input logic wr, input logic rd, input logic [31:0] d);
        logic v1, aw0, ar0, aw1, ar1;
        int   cur;
        ent_t e;
        RESET = rst;
        WREN  = wr;
        RDEN  = rd;
        DI    = d;
        cur   = cyc;
        v1    = head_vis1();
        aw0   = wr && (q0.size() != 512);
        ar0   = rd && (q0.size() != 0);
        aw1   = wr && (q1.size() != 512);
        ar1   = rd && v1;
        @(posedge CLK);
        cyc = cyc + 1;
        if (rst) begin
            model_reset();
        end else begin
            exp_wrerr0 = wr && !aw0;
            exp_rderr0 = rd && !ar0;
            exp_wrerr1 = wr && !aw1;
            exp_rderr1 = rd && !ar1;
            exp_valid0 = ar0;
            if (ar0) exp_do0 = q0.pop_front();
            if (aw0) q0.push_back(d);
            if (ar1) begin
                e         = q1.pop_front();
                last_do1  = e.w;
                last_pop1 = cur;
            end
            if (aw1) begin
                e.w  = d;
                e.wc = cur;
                q1.push_back(e);
            end
        end
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] nxt;
        int          n;
        RESET    = 1'b1;
        WREN     = 1'b0;
        RDEN     = 1'b0;
        DI       = '0;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        model_reset();

        // Reset, with requests that must be ignored while reset is held.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h55);
        chk("reset_count", 64'(count_s), 64'(0));
        chk("reset_do_fwft", 64'(do_f), 64'(0));

        // FWFT single word latency, then a 3-word burst drained back-to-back.
        step(1'b0, 1'b1, 1'b0, 32'hCAFE);
        chk("fwft_cafe_n1_valid", 64'(valid_f), 64'(0));
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("fwft_cafe_n2_valid", 64'(valid_f), 64'(1));
        chk("fwft_cafe_n2_do", 64'(do_f), 64'h0000_CAFE);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("std_cafe_do", 64'(do_s), 64'h0000_CAFE);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 32'h1111_0000 + 32'(i));
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("fwft_burst_head", 64'(do_f), 64'h1111_0001);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("fwft_burst_2", 64'(do_f), 64'h1111_0002);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("fwft_burst_3", 64'(do_f), 64'h1111_0003);
        chk("fwft_burst_3_valid", 64'(valid_f), 64'(1));
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("fwft_burst_done", 64'(valid_f), 64'(0));

        // Write into an empty buffer alongside a rejected read.
        step(1'b0, 1'b1, 1'b1, 32'h2424);
        chk("empty_wr_rd_rderr", 64'(rderr_s), 64'(1));
        chk("empty_wr_rd_count", 64'(count_s), 64'(1));
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Fill to full, then one write too many.
        for (int i = 1; i <= 512; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
        chk("fill_count", 64'(count_s), 64'(512));
        chk("fill_full", 64'(full_s), 64'(1));
        step(1'b0, 1'b1, 1'b0, 32'h201);
        chk("overflow_wrerr", 64'(wrerr_s), 64'(1));
        chk("overflow_count", 64'(count_s), 64'(512));

        // Drain in order; each word is on DO the cycle after its read.
        for (int i = 1; i <= 512; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            chk("drain_do", 64'(do_s), 64'(i));
        end
        chk("drain_empty", 64'(empty_s), 64'(1));
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("underflow_rderr", 64'(rderr_s), 64'(1));
        chk("underflow_rderr_fwft", 64'(rderr_f), 64'(1));

        // Steady simultaneous traffic at 384 words across pointer wrap.
        nxt = 32'h1000;
        for (int i = 0; i < 384; i++) begin
            step(1'b0, 1'b1, 1'b0, nxt);
            nxt = nxt + 1;
        end
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1, 1'b1, nxt);
            nxt = nxt + 1;
        end
        chk("steady_count", 64'(count_s), 64'(384));
        chk("steady_count_fwft", 64'(count_f), 64'(384));
        chk("steady_afull", 64'(af_s), 64'(1));

        // Random traffic: fill-biased, then drain-biased.
        for (int i = 0; i < 1500; i++)
            step(1'b0, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 35, $urandom);
        for (int i = 0; i < 1500; i++)
            step(1'b0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70, $urandom);
        n = 0;
        while (q0.size() != 0 && n < 600) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            n = n + 1;
        end

        // Climb to 200 words under random traffic, then reset mid-stream.
        n = 0;
        while (q0.size() != 200 && n < 3000) begin
            step(1'b0, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30, $urandom);
            n = n + 1;
        end
        chk("pre_reset_count", 64'(count_s), 64'(200));
        step(1'b1, 1'b1, 1'b1, $urandom);
        chk("mid_reset_count", 64'(count_s), 64'(0));
        chk("mid_reset_do", 64'(do_s), 64'(0));
        chk("mid_reset_wrerr", 64'(wrerr_s), 64'(0));
        step(1'b0, 1'b1, 1'b0, 32'hFEED_0036);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_reset_fwft_do", 64'(do_f), 64'hFEED_0036);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("post_reset_std_do", 64'(do_s), 64'hFEED_0036);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tp_trackparam_buffer.md
TP_TRACKPARAM_BUFFER -- requirements
Module: tp_trackparam_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; legal range 1..72.
REQ-002 Parameter DEPTH_LOG2, default 9, log2 of storage depth; DEPTH = 2**DEPTH_LOG2; legal range 4..12.
REQ-003 Parameter FWFT, default 0, read mode: 0 = standard, 1 = first-word-fall-through.
REQ-004 Parameter ALMOST_EMPTY_OFFSET, default 128, almost-empty threshold in words; must be < DEPTH.
REQ-005 Parameter ALMOST_FULL_OFFSET, default 128, almost-full threshold in words; must be < DEPTH.
REQ-006 The clock port SHALL be CLK, input, 1 bit: the single clock; every register in the block is clocked on its rising edge.
REQ-007 The reset port SHALL be RESET, input, 1 bit: synchronous, active-high reset.
REQ-008 DI input DATA_WIDTH: write data. WREN input 1: write request.
REQ-009 RDEN input 1: read request (FWFT=1: pop the head word).
REQ-010 DO output DATA_WIDTH: read data. VALID output 1: DO holds a valid word.
REQ-011 EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL outputs, 1 bit each: status flags.
REQ-012 COUNT output DEPTH_LOG2+1: number of words stored.
REQ-013 WRERR, RDERR outputs, 1 bit each: rejected-request pulses.

Function
REQ-014 A write SHALL be accepted when WREN=1 and FULL=0; DI is stored at the write pointer, which advances modulo DEPTH.
REQ-015 WREN=1 with FULL=1 SHALL drop the data and pulse WRERR for one cycle, even when a read is accepted in the same cycle.
REQ-016 A read SHALL be accepted when RDEN=1 and EMPTY=0; RDEN=1 with EMPTY=1 SHALL pulse RDERR for one cycle with no state change.
REQ-017 FWFT=0: a read accepted in cycle N SHALL drive the word on DO with VALID=1 in cycle N+1; VALID=0 otherwise; DO holds its last value.
REQ-018 FWFT=1: DO SHALL present the head word whenever VALID=1, with EMPTY = not VALID.
REQ-019 FWFT=1: a word written into an empty buffer in cycle N SHALL appear on DO with VALID=1 in cycle N+2.
REQ-020 FWFT=1: after a pop, the next word SHALL appear in the following cycle with no bubble while storage holds data.
REQ-021 COUNT SHALL include the FWFT output-stage word.
REQ-022 COUNT SHALL be unchanged when a write and a read are both accepted, +1 on write only, and -1 on read only.
REQ-023 The flags SHALL be registered and consistent with COUNT in the same cycle: FULL = (COUNT==DEPTH); ALMOSTFULL = (COUNT >= DEPTH-ALMOST_FULL_OFFSET); ALMOSTEMPTY = (COUNT <= ALMOST_EMPTY_OFFSET).
REQ-024 A write to an empty buffer in the same cycle as a rejected read SHALL be accepted.
REQ-025 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-026 With RESET=1 at a clock edge, the block SHALL set: pointers=0, COUNT=0, EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0, VALID=0, DO=0, WRERR=0, RDERR=0.
REQ-027 WREN and RDEN SHALL be ignored while RESET=1, and no error pulses are raised.
REQ-028 A reset mid-operation SHALL discard all stored words; RAM contents are not cleared.

Structure
REQ-029 Shared package tp_fifo_pkg SHALL hold the clog2 function, default depth and offset constants, and the mode encodings.
REQ-030 Storage SHALL be one sub-module, tp_sdp_ram: an inferred simple-dual-port block RAM with a registered read port; all control logic stays in tp_trackparam_buffer.
REQ-031 Illegal parameter values SHALL be reported as elaboration errors.

Verification
REQ-032 Defaults, FWFT=0: write 0x1..0x200 back-to-back -> FULL=1 and COUNT=512 after the 512th write; the 513th write pulses WRERR and COUNT stays 512.
REQ-033 FWFT=0: read the full buffer -> DO sequence 0x1..0x200, each word one cycle after its RDEN; EMPTY=1 afterwards; an extra RDEN pulses RDERR.
REQ-034 FWFT=1: single write of 0xCAFE at cycle N -> VALID=1 and DO=0xCAFE at N+2; continuous RDEN drains a 3-word burst on consecutive cycles with no gap.
REQ-035 Simultaneous WREN and RDEN at COUNT=384 for 1000 cycles with pointer wrap -> COUNT constant 384, ALMOSTFULL=1, output data in order, no errors.
REQ-036 RESET pulsed at COUNT=200 during active traffic -> all outputs at reset values next cycle; the next written word is the first word read.
